coord_pair_logger: RTL and testbench

- Parameterised successor to the two-nibble entry/seven-segment project block.
- Captures (X,Y) hex pairs on an entry strobe into a DEPTH-slot circular store. A "0,0" entry clears the store.
- Live mode shows the current X/Y inputs; review mode steps through the stored pairs oldest-first.
- Drives six active-low seven-segment digits H6..H1 plus status flags.

---
 rtl/proj_pkg.sv | 37 +++
 rtl/seg7_hex_decoder.sv | 12 +
 rtl/coord_pair_logger.sv | 178 +++++++++++++++++
 tb/tb_coord_pair_logger.sv | 251 +++++++++++++++++++++++++
 4 files changed

// File: rtl/proj_pkg.sv
// Shared constants for the coordinate pair logger.
// Holds the active-high seven-segment glyphs ({g,f,e,d,c,b,a}), the hex digit
// table, the mode encodings, and the index helpers used by the slot store.
package proj_pkg;

  localparam logic [6:0] SEG_BLANK = 7'h00;
  localparam logic [6:0] SEG_L     = 7'h38;
  localparam logic [6:0] SEG_E     = 7'h79;
  localparam logic [6:0] SEG_R     = 7'h50;
  localparam logic [6:0] SEG_DASH  = 7'h40;

  localparam logic [6:0] SEG_HEX [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  localparam logic MODE_LIVE   = 1'b0;
  localparam logic MODE_REVIEW = 1'b1;

  // Pointer increment that wraps by comparing against depth, so the store
  // works for any depth, not only powers of two.
  function automatic logic [3:0] wrap_inc(input logic [3:0] p, input logic [4:0] depth);
    logic [4:0] n;
    n = {1'b0, p} + 5'd1;
    return (n == depth) ? 4'd0 : n[3:0];
  endfunction

  // Modular add of two indices that are both already below depth.
  function automatic logic [3:0] wrap_add(input logic [3:0] a, input logic [3:0] b,
                                          input logic [4:0] depth);
    logic [4:0] s;
    s = {1'b0, a} + {1'b0, b};
    if (s >= depth) s = s - depth;
    return s[3:0];
  endfunction

endpackage

// File: rtl/seg7_hex_decoder.sv
// Combinational 4-bit hex digit to active-high seven-segment glyph.
// Ports: hex_i - digit value; seg_o - {g,f,e,d,c,b,a}, 1 = segment lit.
module seg7_hex_decoder
  import proj_pkg::*;
(
  input  logic [3:0] hex_i,
  output logic [6:0] seg_o
);

  assign seg_o = SEG_HEX[hex_i];

endmodule

// File: rtl/coord_pair_logger.sv
// Coordinate pair logger: stores (X,Y) nibble pairs in a DEPTH-slot circular
// store and shows either the live inputs or the stored pairs on six
// active-low seven-segment digits.
// Ports:
//   clock            system clock, rising edge
//   reset            synchronous active-low reset
//   X, Y             entry nibbles
//   enter, step      level strobes, rising edges detected internally
//   mode             0 = live, 1 = review
//   H6..H1           active-low segments {g,f,e,d,c,b,a}, H6 leftmost
//   full, empty      store occupancy flags
//   overflow         sticky: an entry was dropped because the store was full
module coord_pair_logger
  import proj_pkg::*;
#(
  parameter int DEPTH     = 4,
  parameter bit OVERWRITE = 1'b0
) (
  input  logic       clock,
  input  logic       reset,
  input  logic [3:0] X,
  input  logic [3:0] Y,
  input  logic       enter,
  input  logic       mode,
  input  logic       step,
  output logic [6:0] H6,
  output logic [6:0] H5,
  output logic [6:0] H4,
  output logic [6:0] H3,
  output logic [6:0] H2,
  output logic [6:0] H1,
  output logic       full,
  output logic       empty,
  output logic       overflow
);

  localparam logic [4:0] DEPTH_C = 5'(DEPTH);
  localparam int         IW      = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [4:0] count_q, count_d;
  logic [3:0] wr_ptr_q, wr_ptr_d;
  logic [3:0] base_q, base_d;
  logic [3:0] rd_idx_q, rd_idx_d;
  logic       overflow_q, overflow_d;
  logic       enter_q, step_q, mode_q;
  logic       wr_en;
  logic       ent_edge, stp_edge, mode_rise;

  logic [7:0] slot_q [DEPTH];
  logic [IW-1:0] wr_sel, rd_sel;
  logic [7:0] rd_pair;

  logic [6:0] h6_q, h5_q, h4_q, h3_q, h2_q, h1_q;
  logic [6:0] h6_d, h5_d, h4_d, h3_d;
  logic [6:0] seg_x, seg_y, seg_ch, seg_cl, seg_ri, seg_sx, seg_sy;

  assign ent_edge  = enter & ~enter_q;
  assign stp_edge  = step & ~step_q;
  assign mode_rise = mode & ~mode_q;

  always_comb begin
    count_d    = count_q;
    wr_ptr_d   = wr_ptr_q;
    base_d     = base_q;
    rd_idx_d   = rd_idx_q;
    overflow_d = overflow_q;
    wr_en      = 1'b0;
    if (mode == MODE_LIVE) begin
      if (ent_edge) begin
        if (X == 4'd0 && Y == 4'd0) begin
          count_d    = 5'd0;
          wr_ptr_d   = 4'd0;
          base_d     = 4'd0;
          overflow_d = 1'b0;
        end else if (count_q < DEPTH_C) begin
          wr_en    = 1'b1;
          wr_ptr_d = wrap_inc(wr_ptr_q, DEPTH_C);
          count_d  = count_q + 5'd1;
        end else if (OVERWRITE) begin
          // Newest pair replaces the oldest; the window slides forward.
          wr_en    = 1'b1;
          wr_ptr_d = wrap_inc(wr_ptr_q, DEPTH_C);
          base_d   = wrap_inc(base_q, DEPTH_C);
        end else begin
          overflow_d = 1'b1;
        end
      end
    end else begin
      if (mode_rise) begin
        rd_idx_d = 4'd0;
      end else if (stp_edge && count_q != 5'd0) begin
        rd_idx_d = ({1'b0, rd_idx_q} == count_q - 5'd1) ? 4'd0 : rd_idx_q + 4'd1;
      end
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      count_q    <= 5'd0;
      wr_ptr_q   <= 4'd0;
      base_q     <= 4'd0;
      rd_idx_q   <= 4'd0;
      overflow_q <= 1'b0;
      enter_q    <= 1'b0;
      step_q     <= 1'b0;
      mode_q     <= 1'b0;
    end else begin
      count_q    <= count_d;
      wr_ptr_q   <= wr_ptr_d;
      base_q     <= base_d;
      rd_idx_q   <= rd_idx_d;
      overflow_q <= overflow_d;
      enter_q    <= enter;
      step_q     <= step;
      mode_q     <= mode;
    end
  end

  // Slot contents need no reset; writes are still blocked while reset is low.
  assign wr_sel = IW'(wr_ptr_q);
  always_ff @(posedge clock) begin
    if (reset && wr_en) slot_q[wr_sel] <= {X, Y};
  end

  // Review reads are relative to the oldest pair.
  assign rd_sel  = IW'(wrap_add(base_q, rd_idx_q, DEPTH_C));
  assign rd_pair = slot_q[rd_sel];

  seg7_hex_decoder u_dec_x  (.hex_i(X),                   .seg_o(seg_x));
  seg7_hex_decoder u_dec_y  (.hex_i(Y),                   .seg_o(seg_y));
  seg7_hex_decoder u_dec_ch (.hex_i({3'b000, count_q[4]}), .seg_o(seg_ch));
  seg7_hex_decoder u_dec_cl (.hex_i(count_q[3:0]),        .seg_o(seg_cl));
  seg7_hex_decoder u_dec_ri (.hex_i(rd_idx_q),            .seg_o(seg_ri));
  seg7_hex_decoder u_dec_sx (.hex_i(rd_pair[7:4]),        .seg_o(seg_sx));
  seg7_hex_decoder u_dec_sy (.hex_i(rd_pair[3:0]),        .seg_o(seg_sy));

  always_comb begin
    h6_d = overflow_q ? SEG_E : SEG_L;
    h5_d = SEG_BLANK;
    h4_d = seg_x;
    h3_d = seg_y;
    if (mode == MODE_REVIEW) begin
      h6_d = SEG_R;
      h5_d = seg_ri;
      h4_d = (count_q == 5'd0) ? SEG_DASH : seg_sx;
      h3_d = (count_q == 5'd0) ? SEG_DASH : seg_sy;
    end
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      h6_q <= ~SEG_L;
      h5_q <= ~SEG_BLANK;
      h4_q <= ~SEG_BLANK;
      h3_q <= ~SEG_BLANK;
      h2_q <= ~SEG_HEX[0];
      h1_q <= ~SEG_HEX[0];
    end else begin
      h6_q <= ~h6_d;
      h5_q <= ~h5_d;
      h4_q <= ~h4_d;
      h3_q <= ~h3_d;
      h2_q <= ~seg_ch;
      h1_q <= ~seg_cl;
    end
  end

  assign H6       = h6_q;
  assign H5       = h5_q;
  assign H4       = h4_q;
  assign H3       = h3_q;
  assign H2       = h2_q;
  assign H1       = h1_q;
  assign full     = (count_q == DEPTH_C);
  assign empty    = (count_q == 5'd0);
  assign overflow = overflow_q;

endmodule

// File: tb/tb_coord_pair_logger.sv
// Bench for coord_pair_logger: three instances (4/drop, 4/overwrite,
// 5/overwrite) share one stimulus stream. Each has a list-based reference
// model; expectations go into a scoreboard queue tagged with the cycle they
// are due, and a monitor on the falling edge compares them.
module tb_coord_pair_logger;

  logic       clock = 1'b0;
  logic       reset = 1'b0;
  logic [3:0] X = 4'd0, Y = 4'd0;
  logic       enter = 1'b0, mode = 1'b0, step = 1'b0;

  logic [6:0] h6 [3], h5 [3], h4 [3], h3 [3], h2 [3], h1 [3];
  logic       full_o [3], empty_o [3], ovf_o [3];

  coord_pair_logger #(.DEPTH(4), .OVERWRITE(1'b0)) dut0 (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .enter(enter), .mode(mode), .step(step),
    .H6(h6[0]), .H5(h5[0]), .H4(h4[0]), .H3(h3[0]), .H2(h2[0]), .H1(h1[0]),
    .full(full_o[0]), .empty(empty_o[0]), .overflow(ovf_o[0]));

  coord_pair_logger #(.DEPTH(4), .OVERWRITE(1'b1)) dut1 (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .enter(enter), .mode(mode), .step(step),
    .H6(h6[1]), .H5(h5[1]), .H4(h4[1]), .H3(h3[1]), .H2(h2[1]), .H1(h1[1]),
    .full(full_o[1]), .empty(empty_o[1]), .overflow(ovf_o[1]));

  coord_pair_logger #(.DEPTH(5), .OVERWRITE(1'b1)) dut2 (
    .clock(clock), .reset(reset), .X(X), .Y(Y), .enter(enter), .mode(mode), .step(step),
    .H6(h6[2]), .H5(h5[2]), .H4(h4[2]), .H3(h3[2]), .H2(h2[2]), .H1(h1[2]),
    .full(full_o[2]), .empty(empty_o[2]), .overflow(ovf_o[2]));

  always #5 clock = ~clock;

  int cyc = 0;
  always @(posedge clock) cyc <= cyc + 1;

  int total = 0;
  int bad   = 0;

  // Reference model: each store is an oldest-first list.
  int         dep [3] = '{4, 4, 5};
  bit         ow  [3] = '{1'b0, 1'b1, 1'b1};
  logic [7:0] mlist [3][16];
  int         mcnt [3];
  bit         movf [3];
  int         mrd  [3];

  logic [6:0] hexg [16] = '{
    7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
    7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71
  };

  typedef struct {
    int          due;
    int          dut;
    string       name;
    logic [44:0] exp;
  } exp_t;

  exp_t sbq [$];

  function automatic logic [44:0] model_out(int d);
    logic [6:0] a6, a5, a4, a3, a2, a1;
    logic [7:0] pr;
    int c;
    c = mcnt[d];
    if (!mode) begin
      a6 = movf[d] ? 7'h79 : 7'h38;
      a5 = 7'h00;
      a4 = hexg[X];
      a3 = hexg[Y];
    end else begin
      a6 = 7'h50;
      a5 = hexg[mrd[d]];
      if (c == 0) begin
        a4 = 7'h40;
        a3 = 7'h40;
      end else begin
        pr = mlist[d][mrd[d]];
        a4 = hexg[pr[7:4]];
        a3 = hexg[pr[3:0]];
      end
    end
    a2 = hexg[c / 16];
    a1 = hexg[c % 16];
    return {~a6, ~a5, ~a4, ~a3, ~a2, ~a1, (c == dep[d]), (c == 0), movf[d]};
  endfunction

  function automatic logic [44:0] dut_out(int d);
    return {h6[d], h5[d], h4[d], h3[d], h2[d], h1[d], full_o[d], empty_o[d], ovf_o[d]};
  endfunction

  task automatic m_reset();
    for (int d = 0; d < 3; d++) begin
      mcnt[d] = 0;
      movf[d] = 1'b0;
      mrd[d]  = 0;
    end
  endtask

  task automatic m_enter(input logic [3:0] x, input logic [3:0] y);
    if (mode) return;
    for (int d = 0; d < 3; d++) begin
      if (x == 4'd0 && y == 4'd0) begin
        mcnt[d] = 0;
        movf[d] = 1'b0;
      end else if (mcnt[d] < dep[d]) begin
        mlist[d][mcnt[d]] = {x, y};
        mcnt[d]++;
      end else if (ow[d]) begin
        for (int k = 0; k < dep[d] - 1; k++) mlist[d][k] = mlist[d][k+1];
        mlist[d][dep[d]-1] = {x, y};
      end else begin
        movf[d] = 1'b1;
      end
    end
  endtask

  task automatic tick_check(input string name);
    for (int d = 0; d < 3; d++)
      sbq.push_back('{due: cyc + 2, dut: d, name: name, exp: model_out(d)});
    repeat (3) @(negedge clock);
  endtask

  task automatic do_enter(input logic [3:0] x, input logic [3:0] y, input string name);
    @(negedge clock);
    X = x; Y = y; enter = 1'b1;
    @(negedge clock);
    enter = 1'b0;
    m_enter(x, y);
    tick_check(name);
  endtask

  task automatic do_hold(input logic [3:0] x, input logic [3:0] y, input int n);
    @(negedge clock);
    X = x; Y = y; enter = 1'b1;
    repeat (n) @(negedge clock);
    enter = 1'b0;
    m_enter(x, y);
    tick_check("hold_enter");
  endtask

  task automatic do_step(input string name);
    @(negedge clock);
    step = 1'b1;
    @(negedge clock);
    step = 1'b0;
    if (mode)
      for (int d = 0; d < 3; d++)
        if (mcnt[d] > 0) mrd[d] = (mrd[d] + 1) % mcnt[d];
    tick_check(name);
  endtask

  task automatic set_mode(input logic m, input string name);
    @(negedge clock);
    if (m && !mode)
      for (int d = 0; d < 3; d++) mrd[d] = 0;
    mode = m;
    tick_check(name);
  endtask

  // Monitor: compares every expectation on the falling edge of its due cycle.
  always @(negedge clock) begin
    while (sbq.size() > 0 && sbq[0].due <= cyc) begin
      exp_t e;
      logic [44:0] act;
      e = sbq.pop_front();
      act = dut_out(e.dut);
      total++;
      if (e.due != cyc) begin
        bad++;
        $display("FAIL %s dut%0d stale check due=%0d now=%0d", e.name, e.dut, e.due, cyc);
      end else if (act !== e.exp) begin
        bad++;
        $display("FAIL %s dut%0d got=%h expected=%h (H6..H1,full,empty,ovf)",
                 e.name, e.dut, act, e.exp);
      end
    end
  end

  initial begin
    logic [44:0] rst_exp;
    int r;
    m_reset();
    rst_exp = {~7'h38, 7'h7F, 7'h7F, 7'h7F, ~7'h3F, ~7'h3F, 1'b0, 1'b1, 1'b0};

    // Reset held for two clocks, checked while still asserted.
    repeat (2) @(negedge clock);
    for (int d = 0; d < 3; d++)
      sbq.push_back('{due: cyc + 1, dut: d, name: "reset_state", exp: rst_exp});
    repeat (2) @(negedge clock);
    reset = 1'b1;
    tick_check("after_reset");

    // Five entries: fills depth 4 (drop / overwrite) and depth 5.
    do_enter(4'h1, 4'h2, "enter_1");
    do_enter(4'h3, 4'h4, "enter_2");
    do_enter(4'h5, 4'h6, "enter_3");
    do_enter(4'h7, 4'h8, "enter_4");
    do_enter(4'h9, 4'hA, "enter_5_full");
    set_mode(1'b1, "review_start");
    for (int i = 0; i < 5; i++) do_step("review_step");

    // Clear, then review of an empty store.
    set_mode(1'b0, "back_live");
    do_enter(4'h0, 4'h0, "clear");
    set_mode(1'b1, "review_empty");
    do_step("step_empty");

    // Held enter stores once; enter in review stores nothing.
    set_mode(1'b0, "live_again");
    do_hold(4'h2, 4'h3, 10);
    set_mode(1'b1, "review_hold");
    do_enter(4'h5, 4'h5, "enter_in_review");
    do_enter(4'h6, 4'h6, "enter_in_review2");
    do_step("step_hold");

    // Seven entries wrap the depth-5 pointers.
    set_mode(1'b0, "live_wrap");
    do_enter(4'h0, 4'h0, "clear_wrap");
    for (int k = 1; k <= 7; k++) do_enter(4'(k), 4'(k + 8), "wrap_entry");
    set_mode(1'b1, "review_wrap");
    for (int i = 0; i < 6; i++) do_step("review_wrap_step");
    set_mode(1'b0, "live_end_wrap");

    // Reset coinciding with an entry edge wins.
    @(negedge clock);
    X = 4'h4; Y = 4'h4; enter = 1'b1; reset = 1'b0;
    @(negedge clock);
    enter = 1'b0; reset = 1'b1;
    m_reset();
    tick_check("reset_vs_enter");

    // Randomized mix of entries, clears, steps and mode changes.
    for (int i = 0; i < 150; i++) begin
      r = $urandom_range(0, 9);
      if (r == 0)      do_enter(4'h0, 4'h0, "rnd_clear");
      else if (r <= 5) do_enter(4'($urandom_range(1, 15)), 4'($urandom_range(0, 15)), "rnd_enter");
      else if (r <= 7) do_step("rnd_step");
      else             set_mode(~mode, "rnd_mode");
    end

    for (int w = 0; w < 20 && sbq.size() > 0; w++) @(negedge clock);
    if (sbq.size() > 0) begin
      total++;
      bad++;
      $display("FAIL drain pending=%0d expected=0", sbq.size());
    end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
